// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the hazard controller: forwarding selects, memory
// wait-state FSM states and the forwarding priority helper.
package hazard_ctrl_pkg;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_ERR  = 2'b10
   } state_t;

   // MEM result is younger than WB, so it wins when both match
   function automatic logic [1:0] fwd_sel(
      input logic [4:0] rs,
      input logic [4:0] rd_m,
      input logic       we_m,
      input logic [4:0] rd_w,
      input logic       we_w
   );
      if (we_m && (rd_m != 5'd0) && (rd_m == rs))
         return FWD_MEM;
      else if (we_w && (rd_w != 5'd0) && (rd_w == rs))
         return FWD_WB;
      else
         return FWD_RF;
   endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with enable and asynchronous active-low clear.
module sat_counter #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (en && (count != '1))
         count <= count + WIDTH'(1);
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: EX forwarding, load-use and memory wait-state
// stalls, control flushes, memory timeout detection and perf counters.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       Rs1D,
   input  logic [4:0]       Rs2D,
   input  logic [4:0]       Rs1E,
   input  logic [4:0]       Rs2E,
   input  logic [4:0]       RdE,
   input  logic [4:0]       RdM,
   input  logic [4:0]       RdW,
   input  logic             RegWriteE,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic             ResultSrcE0,
   input  logic             PCSrcE,
   input  logic             MemReqM,
   input  logic             MemAckM,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushW,
   output logic             MemErr,
   output logic [CNT_W-1:0] StallCycles,
   output logic [CNT_W-1:0] FlushCount
);

   state_t     state, state_next;
   logic [7:0] wait_cnt, wait_cnt_next;
   logic       lw_stall, mem_stall;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         wait_cnt <= '0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_cnt_next;
      end
   end

   always_comb begin
      state_next    = state;
      wait_cnt_next = wait_cnt;
      unique case (state)
         ST_IDLE: begin
            if (MemReqM && !MemAckM) begin
               state_next    = ST_WAIT;
               wait_cnt_next = 8'd1;
            end
         end
         ST_WAIT: begin
            if (MemAckM || !MemReqM) begin
               state_next    = ST_IDLE;
               wait_cnt_next = '0;
            end else if (wait_cnt == 8'(MEM_TIMEOUT)) begin
               state_next = ST_ERR;
            end else begin
               wait_cnt_next = wait_cnt + 8'd1;
            end
         end
         ST_ERR:  state_next = ST_ERR;
         default: begin
            state_next    = ST_IDLE;
            wait_cnt_next = '0;
         end
      endcase
   end

   // A memory stall freezes EX, so any pending flush waits for the release cycle
   always_comb begin
      ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
      ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
      lw_stall  = ResultSrcE0 && RegWriteE && (RdE != 5'd0) &&
                  ((RdE == Rs1D) || (RdE == Rs2D));
      mem_stall = (MemReqM && !MemAckM) || (state == ST_ERR);
      StallF    = lw_stall || mem_stall;
      StallD    = lw_stall || mem_stall;
      StallE    = mem_stall;
      StallM    = mem_stall;
      FlushW    = mem_stall;
      FlushD    = PCSrcE && !mem_stall;
      FlushE    = (lw_stall || PCSrcE) && !mem_stall;
      MemErr    = (state == ST_ERR);
   end

   sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst),
      .en    (StallF),
      .count (StallCycles)
   );

   sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst),
      .en    (FlushD),
      .count (FlushCount)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// traffic compared against a run-length based behavioural model.
module tb_hazard_ctrl;

   localparam int unsigned TO   = 4;
   localparam int unsigned CW   = 4;
   localparam int          MAXC = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [4:0]    Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic          RegWriteE, RegWriteM, RegWriteW, ResultSrcE0, PCSrcE;
   logic          MemReqM, MemAckM;
   logic [1:0]    ForwardAE, ForwardBE;
   logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
   logic [CW-1:0] StallCycles, FlushCount;

   int n_asserts = 0;
   int n_fail    = 0;

   // model state: consecutive un-acked request cycles, sticky error, counters
   int pend = 0;
   bit err  = 1'b0;
   int sc   = 0;
   int fc   = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RdM(RdM), .RdW(RdW),
      .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
      .MemReqM(MemReqM), .MemAckM(MemAckM),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .MemErr(MemErr),
      .StallCycles(StallCycles), .FlushCount(FlushCount)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [1:0] m_fwd(input logic [4:0] rs);
      if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
      if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
      return 2'b00;
   endfunction

   function automatic bit m_lw();
      return ResultSrcE0 && RegWriteE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
   endfunction

   function automatic bit m_ms();
      return (MemReqM && !MemAckM) || err;
   endfunction

   task automatic check_all(input string tag);
      bit lw, ms;
      lw = m_lw();
      ms = m_ms();
      chk({tag, ".ForwardAE"}, 32'(ForwardAE), 32'(m_fwd(Rs1E)));
      chk({tag, ".ForwardBE"}, 32'(ForwardBE), 32'(m_fwd(Rs2E)));
      chk({tag, ".StallF"}, 32'(StallF), 32'(lw || ms));
      chk({tag, ".StallD"}, 32'(StallD), 32'(lw || ms));
      chk({tag, ".StallE"}, 32'(StallE), 32'(ms));
      chk({tag, ".StallM"}, 32'(StallM), 32'(ms));
      chk({tag, ".FlushW"}, 32'(FlushW), 32'(ms));
      chk({tag, ".FlushD"}, 32'(FlushD), 32'(PCSrcE && !ms));
      chk({tag, ".FlushE"}, 32'(FlushE), 32'((lw || PCSrcE) && !ms));
      chk({tag, ".MemErr"}, 32'(MemErr), 32'(err));
      chk({tag, ".StallCycles"}, 32'(StallCycles), 32'(sc));
      chk({tag, ".FlushCount"}, 32'(FlushCount), 32'(fc));
   endtask

   // Check at negedge, advance model across the posedge, return at posedge+1
   task automatic cycle(input string tag);
      bit ms;
      @(negedge clk);
      check_all(tag);
      @(posedge clk);
      ms = m_ms();
      if (m_lw() || ms) sc = (sc < MAXC) ? sc + 1 : sc;
      if (PCSrcE && !ms) fc = (fc < MAXC) ? fc + 1 : fc;
      if (!err) begin
         pend = (MemReqM && !MemAckM) ? pend + 1 : 0;
         if (pend > int'(TO)) err = 1'b1;
      end
      #1;
   endtask

   task automatic idle_inputs();
      Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
      RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; ResultSrcE0 = 0;
      PCSrcE = 0; MemReqM = 0; MemAckM = 0;
   endtask

   // Asynchronous reset pulse mid-cycle; released at negedge with idle inputs
   task automatic do_reset();
      idle_inputs();
      #2;
      rst = 1'b0;
      pend = 0; err = 1'b0; sc = 0; fc = 0;
      #1;
      chk("rst.MemErr", 32'(MemErr), 32'd0);
      chk("rst.StallCycles", 32'(StallCycles), 32'd0);
      chk("rst.FlushCount", 32'(FlushCount), 32'd0);
      @(negedge clk);
      check_all("rst");
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      idle_inputs();
      #12;
      check_all("reset");
      chk("reset.StallF", 32'(StallF), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // forwarding priority
      RegWriteM = 1; RdM = 5; RegWriteW = 1; RdW = 5; Rs1E = 5; Rs2E = 0;
      #1;
      chk("fwd.mem", 32'(ForwardAE), 32'b10);
      chk("fwd.b_x0", 32'(ForwardBE), 32'b00);
      cycle("fwd1");
      RegWriteM = 0;
      #1;
      chk("fwd.wb", 32'(ForwardAE), 32'b01);
      cycle("fwd2");
      RdW = 0;
      #1;
      chk("fwd.rf", 32'(ForwardAE), 32'b00);
      cycle("fwd3");
      idle_inputs();

      // load-use
      ResultSrcE0 = 1; RegWriteE = 1; RdE = 7; Rs2D = 7;
      #1;
      chk("lw.StallF", 32'(StallF), 32'd1);
      chk("lw.FlushE", 32'(FlushE), 32'd1);
      chk("lw.StallE", 32'(StallE), 32'd0);
      chk("lw.cnt0", 32'(StallCycles), 32'd0);
      cycle("lw");
      chk("lw.cnt1", 32'(StallCycles), 32'd1);
      idle_inputs();

      // branch taken, two cycles
      PCSrcE = 1;
      #1;
      chk("br.FlushD", 32'(FlushD), 32'd1);
      chk("br.StallF", 32'(StallF), 32'd0);
      cycle("br1");
      cycle("br2");
      chk("br.count", 32'(FlushCount), 32'd2);
      idle_inputs();

      // 3-cycle memory wait with a frozen branch in EX
      PCSrcE = 1; MemReqM = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("mw.StallM", 32'(StallM), 32'd1);
         chk("mw.FlushD", 32'(FlushD), 32'd0);
         cycle("mw");
      end
      MemAckM = 1;
      #1;
      chk("mw.ack_stall", 32'(StallF), 32'd0);
      chk("mw.ack_flush", 32'(FlushD), 32'd1);
      cycle("mw_ack");
      idle_inputs();
      cycle("mw_idle");

      // timeout into ERR, then async reset clears it
      MemReqM = 1;
      for (int i = 0; i < int'(TO) + 1; i++) cycle("to");
      chk("to.MemErr", 32'(MemErr), 32'd1);
      MemReqM = 0;
      #1;
      chk("to.held", 32'(StallE), 32'd1);
      cycle("to_err");
      do_reset();

      // saturation of the stall counter
      ResultSrcE0 = 1; RegWriteE = 1; RdE = 3; Rs1D = 3;
      for (int i = 0; i < 20; i++) cycle("sat");
      chk("sat.StallCycles", 32'(StallCycles), 32'(MAXC));
      do_reset();

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
         Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
         RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
         RdW  = 5'($urandom_range(0, 3));
         RegWriteE = 1'($urandom); RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
         ResultSrcE0 = 1'($urandom);
         PCSrcE  = ($urandom_range(0, 3) == 0);
         MemReqM = ($urandom_range(0, 2) != 0);
         MemAckM = ($urandom_range(0, 2) == 0);
         cycle("rand");
         if ((err && $urandom_range(0, 3) == 0) || $urandom_range(0, 59) == 0)
            do_reset();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
